// File: rtl/a2d_spi_resp.sv
// a2d_spi_resp: SPI responder emulating an 8-channel 12-bit A2D, returning the channel commanded in the previous transaction
module a2d_spi_resp (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic        wr_en,
  input  logic [2:0]  wr_chnl,
  input  logic [11:0] wr_data,
  output logic [2:0]  chnl_last,
  output logic        xfer_done,
  output logic        xfer_err
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;
  logic [2:0]  ss_q, ss_d, sclk_q, sclk_d;
  logic [1:0]  mosi_q, mosi_d, age_q, age_d;
  logic [0:0]  state_q, state_d;
  logic [15:0] tx_q, tx_d, rx_q, rx_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  chnl_q, chnl_d;
  logic        done_q, done_d, err_q, err_d;
  logic [11:0] regs_q [8];
  logic [11:0] regs_d [8];
  logic        ss_fall, ss_rise, sclk_rise;
  // falls are only trusted once the sync chain holds real pin samples, so an SS_n held low through reset is ignored
  assign ss_fall   = ss_q[2] & ~ss_q[1] & (age_q == 2'd3);
  assign ss_rise   = ~ss_q[2] & ss_q[1];
  assign sclk_rise = ~sclk_q[2] & sclk_q[1];
  assign MISO      = (state_q == XFER) ? tx_q[15] : 1'b1;
  assign chnl_last = chnl_q;
  assign xfer_done = done_q;
  assign xfer_err  = err_q;
  always_comb begin
    ss_d    = {ss_q[1:0], SS_n};
    sclk_d  = {sclk_q[1:0], SCLK};
    mosi_d  = {mosi_q[0], MOSI};
    age_d   = (age_q == 2'd3) ? age_q : age_q + 2'd1;
    regs_d  = regs_q;
    if (wr_en) regs_d[wr_chnl] = wr_data;
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    cnt_d   = cnt_q;
    chnl_d  = chnl_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (state_q == IDLE) begin
      if (ss_fall) begin
        state_d = XFER;
        tx_d    = {4'h0, regs_q[chnl_q]};
        rx_d    = '0;
        cnt_d   = '0;
      end
    end else if (ss_rise) begin
      state_d = IDLE;
      done_d  = (cnt_q == 5'd16);
      err_d   = (cnt_q != 5'd16);
      chnl_d  = (cnt_q == 5'd16) ? rx_q[13:11] : chnl_q;
    end else if (sclk_rise) begin
      rx_d  = {rx_q[14:0], mosi_q[1]};
      tx_d  = {tx_q[14:0], 1'b0};
      cnt_d = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_q    <= 3'b111;
      sclk_q  <= 3'b111;
      mosi_q  <= 2'b00;
      age_q   <= 2'd0;
      regs_q  <= '{default: 12'h000};
      state_q <= IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      cnt_q   <= '0;
      chnl_q  <= 3'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ss_q    <= ss_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      age_q   <= age_d;
      regs_q  <= regs_d;
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      cnt_q   <= cnt_d;
      chnl_q  <= chnl_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_a2d_spi_resp.sv
// tb_a2d_spi_resp: directed table-driven bench for the A2D SPI responder
module tb_a2d_spi_resp;
  logic clk = 0, rst = 1, SS_n = 1, SCLK = 1, MOSI = 0, wr_en = 0;
  logic [2:0] wr_chnl = 0;
  logic [11:0] wr_data = 0;
  logic MISO, xfer_done, xfer_err;
  logic [2:0] chnl_last;
  int checks = 0, errors = 0, done_n = 0, err_n = 0;

  a2d_spi_resp dut (.clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .wr_en(wr_en), .wr_chnl(wr_chnl), .wr_data(wr_data), .chnl_last(chnl_last),
    .xfer_done(xfer_done), .xfer_err(xfer_err));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (xfer_done) done_n <= done_n + 1;
    if (xfer_err) err_n <= err_n + 1;
  end

  typedef struct {
    logic [15:0] cmd;
    logic [15:0] exp_rd;
    logic [2:0]  exp_chnl;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] ch, input logic [11:0] d);
    @(negedge clk);
    wr_en = 1; wr_chnl = ch; wr_data = d;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic xfer(input logic [15:0] cmd, input int nrise, input int wr_at, input logic [2:0] wch,
                      input logic [11:0] wdat, input int rst_at, output logic [15:0] rd);
    rd = '0;
    @(negedge clk);
    SS_n = 0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nrise; i++) begin
      SCLK = 0;
      MOSI = (i < 16) ? cmd[15-i] : 1'b0;
      if (i == wr_at) begin wr_en = 1; wr_chnl = wch; wr_data = wdat; end
      if (i == rst_at) rst = 1;
      repeat (4) @(negedge clk);
      wr_en = 0;
      if (i == rst_at) begin
        chk("rst_miso", 16'(MISO), 16'd1);
        chk("rst_chnl", 16'(chnl_last), 16'd0);
        rst = 0;
      end
      repeat (12) @(negedge clk);
      rd = {rd[14:0], MISO};
      SCLK = 1;
      repeat (16) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    SS_n = 1;
    repeat (12) @(negedge clk);
  endtask

  task automatic txn(input string nm, input logic [15:0] cmd, input int nrise, input int wr_at,
                     input logic [2:0] wch, input logic [11:0] wdat, input bit chk_rd,
                     input logic [15:0] e_rd, input logic [2:0] e_chnl, input int e_done, input int e_err);
    logic [15:0] rd;
    int d0, e0;
    d0 = done_n; e0 = err_n;
    xfer(cmd, nrise, wr_at, wch, wdat, -1, rd);
    if (chk_rd) chk({nm, "_rd"}, rd, e_rd);
    chk({nm, "_chnl"}, 16'(chnl_last), 16'(e_chnl));
    chk({nm, "_done"}, 16'(done_n - d0), 16'(e_done));
    chk({nm, "_err"}, 16'(err_n - e0), 16'(e_err));
  endtask

  initial begin
    logic [15:0] rd;
    int d0, e0;
    vecs[0] = '{16'h0800, 16'h0ABC, 3'd1};
    vecs[1] = '{16'h0000, 16'h0123, 3'd0};
    for (int k = 1; k < 8; k++) vecs[k+1] = '{16'(k << 11), 16'(12'h101 * (k - 1)), 3'(k)};
    vecs[9] = '{16'h0000, 16'h0707, 3'd0};

    repeat (3) @(negedge clk);
    chk("reset_miso", 16'(MISO), 16'd1);
    chk("reset_chnl", 16'(chnl_last), 16'd0);
    chk("reset_done", 16'(xfer_done), 16'd0);
    chk("reset_err", 16'(xfer_err), 16'd0);
    rst = 0;
    repeat (4) @(negedge clk);

    wr(3'd0, 12'hABC);
    wr(3'd1, 12'h123);
    for (int i = 0; i < 10; i++) begin
      if (i == 2) for (int k = 0; k < 8; k++) wr(3'(k), 12'(12'h101 * k));
      txn($sformatf("vec%0d", i), vecs[i].cmd, 16, -1, 0, 0, 1, vecs[i].exp_rd, vecs[i].exp_chnl, 1, 0);
    end

    wr(3'd3, 12'h0F0);
    txn("coh_a", 16'h1800, 16, -1, 0, 0, 1, 16'h0000, 3'd3, 1, 0);
    txn("coh_b", 16'h1800, 16, 5, 3'd3, 12'h555, 1, 16'h00F0, 3'd3, 1, 0);
    txn("coh_c", 16'h0000, 16, -1, 0, 0, 1, 16'h0555, 3'd0, 1, 0);

    txn("pre_abort", 16'h1000, 16, -1, 0, 0, 1, 16'h0000, 3'd2, 1, 0);
    txn("abort9", 16'h3000, 9, -1, 0, 0, 0, 0, 3'd2, 0, 1);
    txn("over17", 16'h3000, 17, -1, 0, 0, 0, 0, 3'd2, 0, 1);
    txn("zero_sclk", 16'h3000, 0, -1, 0, 0, 0, 0, 3'd2, 0, 1);

    wr(3'd0, 12'hFFF);
    d0 = done_n; e0 = err_n;
    xfer(16'h2800, 16, -1, 0, 0, 7, rd);
    chk("rst_no_done", 16'(done_n - d0), 16'd0);
    chk("rst_no_err", 16'(err_n - e0), 16'd0);
    chk("rst_chnl_after", 16'(chnl_last), 16'd0);
    txn("post_rst", 16'h2800, 16, -1, 0, 0, 1, 16'h0000, 3'd5, 1, 0);

    wr(3'd5, 12'h0A5);
    d0 = done_n; e0 = err_n;
    for (int i = 0; i < 10; i++) begin
      SCLK = 0; repeat (16) @(negedge clk);
      SCLK = 1; repeat (16) @(negedge clk);
    end
    chk("idle_sclk_done", 16'(done_n - d0), 16'd0);
    chk("idle_sclk_err", 16'(err_n - e0), 16'd0);
    chk("idle_sclk_miso", 16'(MISO), 16'd1);
    txn("after_idle", 16'h0800, 16, -1, 0, 0, 1, 16'h00A5, 3'd1, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/a2d_spi_resp.md
# a2d_spi_resp

Synthesizable SPI responder that emulates the 8-channel, 12-bit A2D converter on the DE0 board. It is the far end of the A2D_SS_n/A2D_SCLK/A2D_MOSI/A2D_MISO link driven by the eBike A2D interface. It decodes the channel command in each 16-bit transaction and returns the held sample of the channel commanded in the previous transaction. It serves as the bench A2D model and as an FPGA loopback target, with channel values loaded through a simple write port.

## Interface
- No parameters.
- clk  in  1  system clock (50MHz); all logic on rising edge
- rst  in  1  synchronous, active-high reset
- SS_n  in  1  slave select from initiator, active low, asynchronous to clk
- SCLK  in  1  SPI clock from initiator, idle high, asynchronous to clk
- MOSI  in  1  serial command from initiator
- MISO  out  1  serial data to initiator
- wr_en  in  1  write strobe for sample register file
- wr_chnl  in  3  channel index for write
- wr_data  in  12  sample value for write
- chnl_last  out  3  channel decoded from the last good transaction (next to be returned)
- xfer_done  out  1  one-clk pulse: good 16-bit transaction completed
- xfer_err  out  1  one-clk pulse: transaction ended with bit count ≠ 16

## Operation
- Synchronizers: SS_n, SCLK and MOSI each pass through 2 flops, with a 3rd flop for edge detection. SS_n/SCLK flops reset to 1; MOSI flops reset to 0.
- Edge events: SCLK rise/fall and SS_n fall/rise are detected on synchronized signals only.
- Sample file: 8 x 12-bit registers, all reset to 12'h000. When wr_en is high, regs[wr_chnl] <= wr_data.
- State machine IDLE / XFER:
  - IDLE -> XFER on SS_n fall.
    - Load tx_shft[15:0] <= {4'h0, regs[chnl_last]}.
    - Clear bit_cnt and rx_shft.
  - XFER, on each SCLK rise:
    - rx_shft <= {rx_shft[14:0], MOSI_sync}.
    - tx_shft <= {tx_shft[14:0], 1'b0}.
    - bit_cnt increments, saturating at 31.
  - XFER -> IDLE on SS_n rise:
    - bit_cnt == 16: chnl_last <= rx_shft[13:11], pulse xfer_done.
    - Otherwise: chnl_last unchanged, pulse xfer_err.
- SCLK falls are ignored; MOSI is sampled only at SCLK rise.
- Pipelining: the data returned in transaction N is for the channel commanded in transaction N-1. After reset, the first transaction returns channel 0.
- MISO = tx_shft[15] in XFER, 1 in IDLE.
- Coherency: tx_shft is snapshotted at SS_n fall. A write to the active channel during XFER does not alter in-flight data; it is seen in the next transaction.
- Simultaneous wr_en and SS_n fall to the same channel: the snapshot takes the old value.
- Glitch-free SS_n cycle with zero SCLK edges: bit_cnt = 0, so xfer_err pulses.
- SCLK edges while SS_n is high are ignored.
- rst mid-transaction:
  - Return to IDLE, MISO = 1, chnl_last = 0, all regs cleared, no done/err pulse.
  - The remainder of the interrupted transaction is ignored until the next SS_n fall.

## Timing
- Reset values: MISO = 1, chnl_last = 3'd0, xfer_done = 0, xfer_err = 0, state = IDLE.
- Pin-to-event latency: 3 clk from an SS_n/SCLK pin transition to the internal edge event. MOSI is sampled from its 2-flop version in the same cycle as the rise event.
- MISO changes 1 clk after the internal SCLK-rise event, i.e. 4 clk after the SCLK pin rise. The first bit (bit 15) is valid 4 clk after the SS_n pin fall.
- Initiator constraints:
  - SCLK high and low phases ≥ 6 clk each.
  - SS_n fall to first SCLK fall ≥ 6 clk.
  - Last SCLK rise to SS_n rise ≥ 4 clk.
  - MOSI stable ≥ 4 clk around SCLK rise.
- Any bit-rate meeting these constraints is supported; eBike runs SCLK at clk/32.
- xfer_done/xfer_err assert exactly 1 clk, 4 clk after the SS_n pin rise. chnl_last updates in the same cycle as xfer_done.
- Write port: a value written in cycle t is visible to an SS_n-fall event in cycle ≥ t+1.

## Test plan
- After reset, write ch0=12'hABC and ch1=12'h123. Send cmd 16'h0800 (ch1), then cmd 16'h0000 -> first transaction MISO reads 16'h0ABC, second reads 16'h0123; xfer_done pulses twice; chnl_last = 1 after the first transaction and 0 after the second.
- Sweep all 8 channels with distinct values (ch k = 12'h100*k + k), commanding each in turn -> every read returns the previously commanded channel's value with the upper nibble 0; no xfer_err.
- Write ch3 = 12'h555 mid-transaction while ch3 is being returned (previous value 12'h0F0) -> current read is 16'h00F0, next read is 16'h0555.
- Abort after 9 SCLK rises (SS_n rises early) -> xfer_err pulses once, xfer_done stays 0, chnl_last unchanged. Then send 17 rises -> xfer_err again.
- Assert rst at bit 7 of a transaction, release, then run a full transaction commanding ch5 -> MISO = 1 during reset, returned data 16'h0000 (ch0 cleared), chnl_last = 5 after completion.
- SCLK toggling with SS_n high, then a normal transaction -> no pulses during the toggling; the normal transaction is decoded correctly.
